// File: rtl/lcd_report_queue_ctrl_if.sv
// Request channel into the LCD report queue: valid/ready handshake plus the report fields.
// LCD_HEX_MODE_EN adds the per-request hex_mode bit.
interface lcd_report_queue_ctrl_if #(
  parameter int REG_W   = 4,
  parameter int VALUE_W = 16
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         opcode;
  logic [REG_W-1:0]   reg_idx;
  logic [VALUE_W-1:0] value;
`ifdef LCD_HEX_MODE_EN
  logic               hex_mode;
`endif

  modport master (
    output req_valid, opcode, reg_idx, value,
`ifdef LCD_HEX_MODE_EN
    output hex_mode,
`endif
    input  req_ready
  );

  modport slave (
    input  req_valid, opcode, reg_idx, value,
`ifdef LCD_HEX_MODE_EN
    input  hex_mode,
`endif
    output req_ready
  );
endinterface

// File: rtl/lcd_report_queue_ctrl.sv
// HD44780 status-display driver: queues CPU reports and renders "OPCOD [RRRR]" / "+DDDDD".
// Optional LCD_HEX_MODE_EN: per-request hex_mode shows line 2 as "0x" plus raw hex digits.
module lcd_report_queue_ctrl #(
  parameter int VALUE_W    = 16,
  parameter int REG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int EN_CYC     = 25,
  parameter int CMD_CYC    = 2500,
  parameter int CLR_CYC    = 100000,
  parameter int PWRUP_CYC  = 1000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  lcd_report_queue_ctrl_if.slave   req,
  output logic                     busy,
  output logic                     init_done,
  output logic                     overflow,
  output logic [7:0]               lcd_data,
  output logic                     lcd_rs,
  output logic                     lcd_rw,
  output logic                     lcd_en,
  output logic                     lcd_on,
  output logic                     lcd_blon
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int M1   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int M2   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int NH   = (VALUE_W + 3) / 4;
  localparam int L1_N = REG_W + 8;

  localparam logic [CW-1:0]    PWRUP_LAST = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0]    EN_LAST    = CW'(EN_CYC);
  localparam logic [CW-1:0]    CMD_LAST   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0]    CLR_LAST   = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0]    C1         = 1;
  localparam logic [VALUE_W:0] TEN        = 10;
  localparam logic [VALUE_W:0] ONE_X      = 1;

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_CLR, S_L1, S_ADR2, S_L2} state_t;
  typedef enum logic [1:0] {P_SET, P_EN, P_WAIT} phase_t;

  typedef struct packed {
    logic [2:0]         op;
    logic [REG_W-1:0]   ri;
    logic [VALUE_W-1:0] val;
`ifdef LCD_HEX_MODE_EN
    logic               hex;
`endif
  } req_t;

  state_t state, state_n, after_st;
  phase_t phase, phase_n;
  logic [CW-1:0] cnt, cnt_n, wait_last;
  logic [4:0]    idx, idx_n;
  logic          en_n, rs_n, cur_rs, last_byte, pop;
  logic [7:0]    data_n, cur_byte;

  // ---------------- request FIFO ----------------
  req_t           mem [FIFO_DEPTH];
  req_t           wdata, head;
  logic [AW:0]    wptr, rptr;
  logic           empty, full, push;

  assign empty         = (wptr == rptr);
  assign full          = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push          = req.req_valid && !full;
  assign req.req_ready = !full;
  assign head          = mem[rptr[AW-1:0]];

  always_comb begin
    wdata     = '0;
    wdata.op  = req.opcode;
    wdata.ri  = req.reg_idx;
    wdata.val = req.value;
`ifdef LCD_HEX_MODE_EN
    wdata.hex = req.hex_mode;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (req.req_valid && full) overflow <= 1'b1;
    end
  end

  // ---------------- latched request + decimal converter ----------------
  logic [2:0]         op_q;
  logic [REG_W-1:0]   reg_q;
  logic [VALUE_W-1:0] val_q;
  logic               hex_q;
  logic [VALUE_W:0]   hext, hmag, conv_rem;
  logic [2:0]         conv_cnt;
  logic [4:0][3:0]    dig;

  // one extra bit so the most negative value still has a representable magnitude
  assign hext = {head.val[VALUE_W-1], head.val};
  assign hmag = head.val[VALUE_W-1] ? (~hext + ONE_X) : hext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      hex_q    <= 1'b0;
      conv_rem <= '0;
      conv_cnt <= '0;
      dig      <= '0;
    end else if (pop) begin
      op_q     <= head.op;
      reg_q    <= head.ri;
      val_q    <= head.val;
`ifdef LCD_HEX_MODE_EN
      hex_q    <= head.hex;
      conv_cnt <= head.hex ? 3'd0 : 3'd5;
`else
      hex_q    <= 1'b0;
      conv_cnt <= 3'd5;
`endif
      conv_rem <= hmag;
    end else if (conv_cnt != 3'd0) begin
      // least significant digit first; after five steps dig[4] is the leading digit
      dig      <= {4'(conv_rem % TEN), dig[4:1]};
      conv_rem <= conv_rem / TEN;
      conv_cnt <= conv_cnt - 3'd1;
    end
  end

  function automatic logic [39:0] op_str(input logic [2:0] op);
    case (op)
      3'd0:    op_str = "LOAD ";
      3'd1:    op_str = "ADD  ";
      3'd2:    op_str = "ADDI ";
      3'd3:    op_str = "SUB  ";
      3'd4:    op_str = "SUBI ";
      3'd5:    op_str = "MUL  ";
      3'd6:    op_str = "CLEAR";
      default: op_str = "DPL  ";
    endcase
  endfunction

  // ---------------- byte selection for the current state/index ----------------
  logic [39:0]     opname;
`ifdef LCD_HEX_MODE_EN
  logic [NH*4-1:0] hex_raw;
  logic [3:0]      nib;
  assign hex_raw = (NH*4)'(val_q);
`endif
  assign opname = op_str(op_q);

  always_comb begin
    cur_byte  = 8'h00;
    cur_rs    = 1'b0;
    last_byte = 1'b0;
    after_st  = S_IDLE;
`ifdef LCD_HEX_MODE_EN
    nib       = 4'h0;
`endif
    case (state)
      S_INIT: begin
        case (idx)
          5'd0, 5'd1: cur_byte = 8'h38;
          5'd2:       cur_byte = 8'h0C;
          5'd3:       cur_byte = 8'h01;
          default:    cur_byte = 8'h06;
        endcase
        last_byte = (idx == 5'd4);
      end
      S_CLR: begin
        cur_byte  = 8'h01;
        last_byte = 1'b1;
        after_st  = S_L1;
      end
      S_L1: begin
        cur_rs    = 1'b1;
        last_byte = (idx == 5'(L1_N - 1));
        after_st  = S_ADR2;
        if (idx < 5'd5) begin
          for (int p = 0; p < 5; p++)
            if (idx == 5'(p)) cur_byte = opname[39-8*p -: 8];
        end else if (idx == 5'd5)          cur_byte = 8'h20;
        else if (idx == 5'd6)              cur_byte = 8'h5B;
        else if (idx == 5'(L1_N - 1))      cur_byte = 8'h5D;
        else begin
          for (int b = 0; b < REG_W; b++)
            if (idx == 5'(REG_W + 6 - b)) cur_byte = reg_q[b] ? 8'h31 : 8'h30;
        end
      end
      S_ADR2: begin
        cur_byte  = 8'hC0;
        last_byte = 1'b1;
        after_st  = (op_q == 3'd6) ? S_IDLE : S_L2;
      end
      S_L2: begin
        cur_rs = 1'b1;
        if (hex_q) begin
`ifdef LCD_HEX_MODE_EN
          last_byte = (idx == 5'(NH + 1));
          if (idx == 5'd0)      cur_byte = 8'h30;
          else if (idx == 5'd1) cur_byte = 8'h78;
          else begin
            for (int k = 0; k < NH; k++)
              if (idx == 5'(k + 2)) nib = hex_raw[(NH-1-k)*4 +: 4];
            cur_byte = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
          end
`endif
        end else begin
          last_byte = (idx == 5'd5);
          if (idx == 5'd0) cur_byte = val_q[VALUE_W-1] ? 8'h2D : 8'h2B;
          else begin
            for (int k = 0; k < 5; k++)
              if (idx == 5'(k + 1)) cur_byte = {4'h3, dig[4-k]};
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- main FSM ----------------
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt;
    idx_n     = idx;
    en_n      = lcd_en;
    data_n    = lcd_data;
    rs_n      = lcd_rs;
    pop       = 1'b0;
    wait_last = (lcd_data == 8'h01 && !lcd_rs) ? CLR_LAST : CMD_LAST;
    case (state)
      S_PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          state_n = S_INIT;
          phase_n = P_SET;
          cnt_n   = '0;
          idx_n   = '0;
        end else cnt_n = cnt + C1;
      end
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_CLR;
          phase_n = P_SET;
          idx_n   = '0;
        end
      end
      default: begin
        case (phase)
          P_SET: begin
            data_n  = cur_byte;
            rs_n    = cur_rs;
            phase_n = P_EN;
            cnt_n   = '0;
          end
          // first P_EN cycle is the setup cycle with en still low
          P_EN: begin
            if (cnt == EN_LAST) begin
              en_n    = 1'b0;
              phase_n = P_WAIT;
              cnt_n   = '0;
            end else begin
              en_n  = 1'b1;
              cnt_n = cnt + C1;
            end
          end
          default: begin
            if (cnt == wait_last) begin
              phase_n = P_SET;
              cnt_n   = '0;
              if (last_byte) begin
                idx_n   = '0;
                state_n = after_st;
              end else idx_n = idx + 5'd1;
            end else cnt_n = cnt + C1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_PWRUP;
      phase     <= P_SET;
      cnt       <= '0;
      idx       <= '0;
      lcd_en    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      lcd_en   <= en_n;
      lcd_data <= data_n;
      lcd_rs   <= rs_n;
      if (state == S_INIT && state_n == S_IDLE) init_done <= 1'b1;
    end
  end

  assign busy     = (state != S_IDLE) || !empty;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;
endmodule
